// File: rtl/tpg_mux.sv
// tpg_mux: test-pattern generator and AXI4-Stream source selector.
// Produces a gap-free raster in one of four patterns or forwards one of
// NUM_IN upstream streams.  Source and pattern changes are only applied at
// frame boundaries.  Frame/line statistics are built when TPG_STATS_EN is
// defined; otherwise the statistics outputs are tied to zero.
module tpg_mux #(
  parameter int WIDTH  = 24,
  parameter int HVALID = 640,
  parameter int VVALID = 480,
  parameter int NUM_IN = 2
) (
  input  logic                    axis_clk,
  input  logic                    rst,
  input  logic [2:0]              sel_i,
  input  logic [1:0]              pattern_i,
  input  logic [23:0]             solid_i,
  input  logic [NUM_IN-1:0]       in_axis_tvalid,
  input  logic [NUM_IN-1:0]       in_axis_tuser,
  input  logic [NUM_IN-1:0]       in_axis_tlast,
  input  logic [NUM_IN*WIDTH-1:0] in_axis_tdata,
  output logic [NUM_IN-1:0]       in_axis_tready,
  output logic                    out_axis_tvalid,
  output logic                    out_axis_tuser,
  output logic                    out_axis_tlast,
  output logic [WIDTH-1:0]        out_axis_tdata,
  input  logic                    out_axis_tready,
  output logic [15:0]             frame_count_o,
  output logic [15:0]             line_err_o,
  output logic [1:0]              status_o
);

  localparam int          BAR_W      = HVALID / 8;
  localparam logic [9:0]  H_LAST     = 10'(HVALID - 1);
  localparam logic [9:0]  V_LAST     = 10'(VVALID - 1);
  localparam logic [9:0]  BAR_LAST   = 10'(BAR_W - 1);
  localparam logic [10:0] OLINE_LAST = 11'(VVALID - 1);
  localparam logic [2:0]  NUM_SEL    = 3'(NUM_IN);

  localparam logic [1:0] PAT_COORD = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_SOLID = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  // Source selection and frame tracking state
  logic [2:0]  active_sel_q;
  logic        frame_idle_q, frame_idle_d;
  logic [10:0] oline_q, oline_d;
  logic [10:0] oline_base_s;

  // Generator state
  logic [9:0]  h_q, v_q;
  logic [9:0]  bar_cnt_q;
  logic [2:0]  bar_idx_q;
  logic [1:0]  cur_pat_q;

  // Misc combinational
  logic             gen_sel_s;
  logic             hs_s;
  logic             gen_hs_s;
  logic             switch_s;
  logic             restart_s;
  logic [2:0]       sel_norm_s;
  logic             gen_user_s;
  logic             gen_last_s;
  logic [23:0]      gen_pix_s;
  logic [WIDTH-1:0] gen_data_s;

  assign gen_sel_s  = (active_sel_q == 3'd0);
  assign hs_s       = out_axis_tvalid & out_axis_tready;
  assign gen_hs_s   = hs_s & gen_sel_s;
  // Out-of-range requests fall back to the generator.
  assign sel_norm_s = (sel_i > NUM_SEL) ? 3'd0 : sel_i;
  // The source may only change between frames, on a cycle with no transfer.
  assign switch_s   = frame_idle_q & ~hs_s;
  assign restart_s  = switch_s & (sel_norm_s == 3'd0) & (active_sel_q != 3'd0);
  assign gen_user_s = (h_q == 10'd0) && (v_q == 10'd0);
  assign gen_last_s = (h_q == H_LAST);

  // Generator pixel value for the current raster position and pattern
  always_comb begin
    gen_pix_s = 24'h000000;
    case (cur_pat_q)
      PAT_COORD: gen_pix_s = {2'b11, v_q, 2'b11, h_q};
      PAT_BARS:  gen_pix_s = {{8{bar_idx_q[2]}}, {8{bar_idx_q[1]}}, {8{bar_idx_q[0]}}};
      PAT_SOLID: gen_pix_s = solid_i;
      PAT_CHECK: gen_pix_s = {24{h_q[5] ^ v_q[5]}};
      default:   gen_pix_s = 24'h000000;
    endcase
    gen_data_s        = '0;
    gen_data_s[23:0]  = gen_pix_s;
  end

  // Output mux: generator or zero-latency passthrough of the selected input
  always_comb begin
    out_axis_tvalid = 1'b0;
    out_axis_tuser  = 1'b0;
    out_axis_tlast  = 1'b0;
    out_axis_tdata  = '0;
    in_axis_tready  = '0;
    if (rst) begin
      out_axis_tvalid = 1'b0;
    end else if (gen_sel_s) begin
      out_axis_tvalid = 1'b1;
      out_axis_tuser  = gen_user_s;
      out_axis_tlast  = gen_last_s;
      out_axis_tdata  = gen_data_s;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (active_sel_q == 3'(k + 1)) begin
          out_axis_tvalid   = in_axis_tvalid[k];
          out_axis_tuser    = in_axis_tuser[k];
          out_axis_tlast    = in_axis_tlast[k];
          out_axis_tdata    = in_axis_tdata[k*WIDTH +: WIDTH];
          in_axis_tready[k] = out_axis_tready;
        end else begin
          in_axis_tready[k] = 1'b0;
        end
      end
    end
  end

  // Frame tracker next state: a tuser beat is line 0, a tlast beat closes a line
  always_comb begin
    frame_idle_d = frame_idle_q;
    oline_d      = oline_q;
    oline_base_s = out_axis_tuser ? 11'd0 : oline_q;
    if (hs_s) begin
      if (out_axis_tuser) begin
        frame_idle_d = 1'b0;
      end else begin
        frame_idle_d = frame_idle_q;
      end
      if (out_axis_tlast) begin
        oline_d = oline_base_s + 11'd1;
        if (oline_base_s == OLINE_LAST) begin
          frame_idle_d = 1'b1;
        end else begin
          oline_d = oline_base_s + 11'd1;
        end
      end else begin
        oline_d = oline_base_s;
      end
    end else begin
      oline_d = oline_q;
    end
  end

  // Frame tracker and active source registers
  always_ff @(posedge axis_clk) begin
    if (rst) begin
      active_sel_q <= 3'd0;
      frame_idle_q <= 1'b1;
      oline_q      <= 11'd0;
    end else begin
      frame_idle_q <= frame_idle_d;
      oline_q      <= oline_d;
      if (switch_s) begin
        active_sel_q <= sel_norm_s;
      end else begin
        active_sel_q <= active_sel_q;
      end
    end
  end

  // Raster generator: advances on its own handshakes, restarts when reselected.
  // The pattern is captured as the raster enters (0,0) so it is fixed for the
  // whole frame, including while pixel (0,0) is stalled.
  always_ff @(posedge axis_clk) begin
    if (rst || restart_s) begin
      h_q       <= 10'd0;
      v_q       <= 10'd0;
      bar_cnt_q <= 10'd0;
      bar_idx_q <= 3'd0;
      cur_pat_q <= pattern_i;
    end else if (gen_hs_s) begin
      if (h_q == H_LAST) begin
        h_q       <= 10'd0;
        bar_cnt_q <= 10'd0;
        bar_idx_q <= 3'd0;
        if (v_q == V_LAST) begin
          v_q       <= 10'd0;
          cur_pat_q <= pattern_i;
        end else begin
          v_q <= v_q + 10'd1;
        end
      end else begin
        h_q <= h_q + 10'd1;
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_q <= 10'd0;
          bar_idx_q <= bar_idx_q + 3'd1;
        end else begin
          bar_cnt_q <= bar_cnt_q + 10'd1;
        end
      end
    end else begin
      h_q <= h_q;
    end
  end

`ifdef TPG_STATS_EN
  localparam logic [10:0] COL_LAST = 11'(HVALID - 1);
  localparam logic [10:0] COL_FULL = 11'(HVALID);

  logic [10:0] ocol_q, ocol_d;
  logic [10:0] col_base_s;
  logic        line_ovf_q, line_ovf_d;
  logic        ovf_base_s;
  logic        col_err_s;
  logic [15:0] frame_cnt_q;
  logic [15:0] line_err_q;
  logic        err_sticky_q;

  // Column tracking; an over-long line is flagged once, its tlast is not recounted
  always_comb begin
    col_base_s = out_axis_tuser ? 11'd0 : ocol_q;
    ovf_base_s = out_axis_tuser ? 1'b0 : line_ovf_q;
    ocol_d     = ocol_q;
    line_ovf_d = line_ovf_q;
    col_err_s  = 1'b0;
    if (hs_s) begin
      if (out_axis_tlast) begin
        ocol_d     = 11'd0;
        line_ovf_d = 1'b0;
        col_err_s  = (col_base_s != COL_LAST) & ~ovf_base_s;
      end else if (col_base_s == COL_LAST) begin
        ocol_d     = COL_FULL;
        line_ovf_d = 1'b1;
        col_err_s  = 1'b1;
      end else if (col_base_s == COL_FULL) begin
        ocol_d     = COL_FULL;
        line_ovf_d = ovf_base_s;
      end else begin
        ocol_d     = col_base_s + 11'd1;
        line_ovf_d = ovf_base_s;
      end
    end else begin
      col_err_s = 1'b0;
    end
  end

  // Statistics counters and sticky line-error flag
  always_ff @(posedge axis_clk) begin
    if (rst) begin
      ocol_q       <= 11'd0;
      line_ovf_q   <= 1'b0;
      frame_cnt_q  <= 16'd0;
      line_err_q   <= 16'd0;
      err_sticky_q <= 1'b0;
    end else begin
      ocol_q     <= ocol_d;
      line_ovf_q <= line_ovf_d;
      if (hs_s && out_axis_tuser) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end else begin
        frame_cnt_q <= frame_cnt_q;
      end
      if (col_err_s) begin
        line_err_q   <= line_err_q + 16'd1;
        err_sticky_q <= 1'b1;
      end else begin
        line_err_q   <= line_err_q;
      end
    end
  end

  assign frame_count_o = frame_cnt_q;
  assign line_err_o    = line_err_q;
  assign status_o      = {err_sticky_q, frame_idle_q};
`else
  assign frame_count_o = 16'd0;
  assign line_err_o    = 16'd0;
  assign status_o      = {1'b0, frame_idle_q};
`endif

endmodule

// File: tb/tb_tpg_mux.sv
// Self-checking bench for tpg_mux (small raster: 64x8, two inputs).
module tb_tpg_mux;
  localparam int W  = 24;
  localparam int HV = 64;
  localparam int VV = 8;
  localparam int NI = 2;
  localparam int BW = HV / 8;
  localparam int FR = HV * VV;
`ifdef TPG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    sel;
  logic [1:0]    pattern;
  logic [23:0]   solid;
  logic [NI-1:0] in_tvalid, in_tuser, in_tlast, in_tready;
  logic [NI*W-1:0] in_tdata;
  logic          out_tvalid, out_tuser, out_tlast, out_tready;
  logic [W-1:0]  out_tdata;
  logic [15:0]   fcnt, lerr;
  logic [1:0]    status;

  int total = 0;
  int bad   = 0;
  logic [25:0] sb[$];
  bit sb_en = 0, stall_chk = 0, prev_stall = 0, rdy1_chk = 0;
  logic [25:0] prev_word;

  typedef struct {
    logic [1:0]  pat;
    logic [23:0] solid;
    int          idx;
    logic [23:0] data;
    logic        user;
    logic        last;
  } vec_t;
  vec_t vecs[13];

  always #5 clk = ~clk;

  tpg_mux #(.WIDTH(W), .HVALID(HV), .VVALID(VV), .NUM_IN(NI)) dut (
    .axis_clk(clk), .rst(rst), .sel_i(sel), .pattern_i(pattern), .solid_i(solid),
    .in_axis_tvalid(in_tvalid), .in_axis_tuser(in_tuser), .in_axis_tlast(in_tlast),
    .in_axis_tdata(in_tdata), .in_axis_tready(in_tready),
    .out_axis_tvalid(out_tvalid), .out_axis_tuser(out_tuser), .out_axis_tlast(out_tlast),
    .out_axis_tdata(out_tdata), .out_axis_tready(out_tready),
    .frame_count_o(fcnt), .line_err_o(lerr), .status_o(status)
  );

  function automatic logic [23:0] exp_pix(input logic [1:0] pat, input int h, input int v,
                                          input logic [23:0] sc);
    logic [9:0] hh, vv;
    int b;
    logic [2:0] bb;
    hh = h[9:0];
    vv = v[9:0];
    b  = h / BW;
    bb = b[2:0];
    case (pat)
      2'd0:    return {2'b11, vv, 2'b11, hh};
      2'd1:    return {{8{bb[2]}}, {8{bb[1]}}, {8{bb[0]}}};
      2'd2:    return sc;
      default: return (hh[5] ^ vv[5]) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push_frame(input logic [1:0] pat, input logic [23:0] sc);
    for (int v = 0; v < VV; v++)
      for (int h = 0; h < HV; h++)
        sb.push_back({exp_pix(pat, h, v, sc), (h == 0 && v == 0), (h == HV - 1)});
  endtask

  // One clock: sample outputs on the falling edge, then advance past the rising edge.
  task automatic cyc();
    logic [25:0] w, e;
    @(negedge clk);
    w = {out_tdata[23:0], out_tuser, out_tlast};
    if (sb_en && out_tvalid && out_tready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_beat: got %0h want none", w);
      end else begin
        e = sb.pop_front();
        check("sb_beat", 32'(w), 32'(e));
      end
    end
    if (stall_chk && prev_stall) check("stall_hold", 32'(w), 32'(prev_word));
    prev_stall = out_tvalid && !out_tready;
    prev_word  = w;
    if (rdy1_chk) check("in1_tready_low", 32'(in_tready[1]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] pat);
    rst = 1'b1; pattern = pat; sel = 3'd0; out_tready = 1'b1;
    in_tvalid = '0; in_tuser = '0; in_tlast = '0;
    prev_stall = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{2'd1, 24'h0,      0,   24'h000000, 1'b1, 1'b0};
    vecs[1]  = '{2'd1, 24'h0,      7,   24'h000000, 1'b0, 1'b0};
    vecs[2]  = '{2'd1, 24'h0,      8,   24'h0000FF, 1'b0, 1'b0};
    vecs[3]  = '{2'd1, 24'h0,      16,  24'h00FF00, 1'b0, 1'b0};
    vecs[4]  = '{2'd1, 24'h0,      40,  24'hFF00FF, 1'b0, 1'b0};
    vecs[5]  = '{2'd1, 24'h0,      63,  24'hFFFFFF, 1'b0, 1'b1};
    vecs[6]  = '{2'd1, 24'h0,      72,  24'h0000FF, 1'b0, 1'b0};
    vecs[7]  = '{2'd3, 24'h0,      31,  24'h000000, 1'b0, 1'b0};
    vecs[8]  = '{2'd3, 24'h0,      32,  24'hFFFFFF, 1'b0, 1'b0};
    vecs[9]  = '{2'd2, 24'h123456, 5,   24'h123456, 1'b0, 1'b0};
    vecs[10] = '{2'd0, 24'h0,      202, 24'hC03C0A, 1'b0, 1'b0};
    vecs[11] = '{2'd0, 24'h0,      511, 24'hC07C3F, 1'b0, 1'b1};
    vecs[12] = '{2'd0, 24'h0,      512, 24'hC00C00, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1; pattern = 2'd0; sel = 3'd0; solid = 24'h0; out_tready = 1'b1;
    in_tvalid = '0; in_tuser = '0; in_tlast = '0;
    in_tdata = {24'h222222, 24'h111111};
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_tvalid", 32'(out_tvalid), 32'd0);
    check("rst_fcnt", 32'(fcnt), 32'd0);
    check("rst_lerr", 32'(lerr), 32'd0);
    check("rst_status", 32'(status), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Coord frame under constant ready, plus first pixel of the next frame
    push_frame(2'd0, 24'h0);
    sb.push_back({24'hC00C00, 1'b1, 1'b0});
    sb_en = 1'b1;
    repeat (FR + 1) cyc();
    sb_en = 1'b0;
    check("a_drained", 32'(sb.size()), 32'd0);
    check("a_fcnt", 32'(fcnt), STATS ? 32'd2 : 32'd0);
    check("a_status", 32'(status), 32'd0);
    sb.delete();

    // Table of single-pixel probes
    for (int i = 0; i < 13; i++) begin
      do_reset(vecs[i].pat);
      solid = vecs[i].solid;
      repeat (vecs[i].idx) cyc();
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'({out_tdata[23:0], out_tuser, out_tlast}),
            32'({vecs[i].data, vecs[i].user, vecs[i].last}));
      @(posedge clk); #1;
    end

    // Random ready: same sequence, stable data while stalled
    do_reset(2'd0);
    push_frame(2'd0, 24'h0);
    sb_en = 1'b1; stall_chk = 1'b1;
    for (int n = 0; n < 8 * FR && sb.size() > 0; n++) begin
      out_tready = 1'($urandom_range(0, 1));
      cyc();
    end
    check("b_drained", 32'(sb.size()), 32'd0);
    stall_chk = 1'b0; sb_en = 1'b0; out_tready = 1'b1;
    sb.delete();

    // Source request mid-frame: generator finishes the frame first
    do_reset(2'd0);
    push_frame(2'd0, 24'h0);
    sb_en = 1'b1; rdy1_chk = 1'b1;
    repeat (100) cyc();
    sel = 3'd1;
    in_tvalid[0] = 1'b1; in_tuser[0] = 1'b0; in_tdata[23:0] = 24'h111111;
    for (int n = 0; n < 2 * FR && sb.size() > 0; n++) cyc();
    check("c_drained", 32'(sb.size()), 32'd0);
    check("c_idle", 32'(status[0]), 32'd1);
    out_tready = 1'b0;
    in_tuser[0] = 1'b1; in_tlast[0] = 1'b0; in_tdata[23:0] = 24'hABCDEF;
    @(negedge clk);
    check("c_in0_tready_before", 32'(in_tready[0]), 32'd0);
    @(posedge clk); #1;
    out_tready = 1'b1;
    sb.push_back({24'hABCDEF, 1'b1, 1'b0});
    @(negedge clk);
    check("c_in0_tready_after", 32'(in_tready[0]), 32'd1);
    check("c_in0_tuser_pass", 32'({out_tdata[23:0], out_tuser, out_tlast}), 32'({24'hABCDEF, 1'b1, 1'b0}));
    @(posedge clk); #1;
    sb.delete();
    check("c_busy", 32'(status[0]), 32'd0);

    // Short line (HV-1 pixels) from input 0
    for (int j = 1; j <= HV - 2; j++) begin
      in_tuser[0] = 1'b0;
      in_tlast[0] = (j == HV - 2);
      in_tdata[23:0] = 24'($urandom);
      sb.push_back({in_tdata[23:0], 1'b0, in_tlast[0]});
      cyc();
    end
    check("d_lerr_short", 32'(lerr), STATS ? 32'd1 : 32'd0);
    check("d_status_short", 32'(status), STATS ? 32'd2 : 32'd0);

    // Over-long line: flagged once when the column reaches HV, tlast not recounted
    for (int j = 0; j < HV - 1; j++) begin
      in_tlast[0] = 1'b0;
      in_tdata[23:0] = 24'($urandom);
      sb.push_back({in_tdata[23:0], 1'b0, 1'b0});
      cyc();
    end
    check("d_lerr_full", 32'(lerr), STATS ? 32'd1 : 32'd0);
    in_tdata[23:0] = 24'h0F0F0F;
    sb.push_back({24'h0F0F0F, 1'b0, 1'b0});
    cyc();
    check("d_lerr_ovf", 32'(lerr), STATS ? 32'd2 : 32'd0);
    in_tlast[0] = 1'b1;
    sb.push_back({24'h0F0F0F, 1'b0, 1'b1});
    cyc();
    check("d_lerr_ovf_tlast", 32'(lerr), STATS ? 32'd2 : 32'd0);
    check("d_sb_drained", 32'(sb.size()), 32'd0);
    sb_en = 1'b0; rdy1_chk = 1'b0;
    in_tvalid = '0; in_tlast = '0;
    sb.delete();

    // Reset mid-frame at pixel (10,5)
    do_reset(2'd0);
    repeat (5 * HV + 10) cyc();
    @(negedge clk);
    check("e_pre_rst_pixel", 32'({out_tdata[23:0], out_tuser, out_tlast}),
          32'({exp_pix(2'd0, 10, 5, 24'h0), 1'b0, 1'b0}));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("e_rst_tvalid", 32'(out_tvalid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("e_restart_pixel", 32'({out_tvalid, out_tdata[23:0], out_tuser, out_tlast}),
          32'({1'b1, 24'hC00C00, 1'b1, 1'b0}));
    check("e_status", 32'(status), 32'd1);
    check("e_fcnt", 32'(fcnt), 32'd0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tpg_mux.md
# tpg_mux

Parametrised second-generation test-pattern generator and AXI4-Stream source selector for the video output path. It generates a gap-free raster in one of four selectable patterns, or forwards one of `NUM_IN` upstream streams. Source and pattern changes take effect only at frame boundaries. It sits between the capture/processing streams and the output FIFO.

## Interface
- `WIDTH`, 24: tdata width; must be ≥ 24, bits above 23 driven 0 by the generator.
- `HVALID`, 640: pixels per line; multiple of 8, ≤ 1024.
- `VVALID`, 480: lines per frame, ≤ 1024.
- `NUM_IN`, 2: number of upstream stream inputs, 1..7.
- `axis_clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `sel_i`  in  3  source request: 0 = generator, 1..NUM_IN = input k-1; values > NUM_IN mean generator.
- `pattern_i`  in  2  0 coord, 1 colour bars, 2 solid, 3 checker.
- `solid_i`  in  24  solid colour {R,G,B}.
- `in_axis_tvalid/tuser/tlast`  in  NUM_IN  per-input sideband.
- `in_axis_tdata`  in  NUM_IN*WIDTH  input k in bits [k*WIDTH +: WIDTH].
- `in_axis_tready`  out  NUM_IN  per-input ready.
- `out_axis_tvalid/tuser/tlast`  out  1 each; `out_axis_tdata`  out  WIDTH.
- `out_axis_tready`  in  1.
- `frame_count_o`  out  16  output frames started.
- `line_err_o`  out  16  malformed output lines.
- `status_o`  out  2  [0] frame_idle, [1] sticky line error.

## Operation
- Output mux is driven by the registered `active_sel`.
  - Selected input: tvalid, tuser, tlast and tdata are passed through combinationally, and its tready = `out_axis_tready`.
  - All other inputs: tready = 0.
- Frame tracker runs on every output handshake (`out_axis_tvalid & out_axis_tready`), whatever the source.
  - Column counter `ocol` and line counter `oline`.
  - tuser handshake: `frame_idle` ← 0, `oline` ← 0.
  - tlast handshake: `ocol` ← 0, `oline` ← `oline` + 1.
  - tlast handshake with `oline` = VVALID-1: `frame_idle` ← 1.
- Source switch: while `frame_idle` = 1 and no handshake occurs this cycle, `active_sel` ← `sel_i`. The switch is never applied mid-frame.
- Generator behaviour:
  - Whenever `active_sel` is newly set to the generator, it restarts at (h=0, v=0).
  - While not selected, its counters hold.
  - tvalid is held high continuously; counters advance only on handshake.
  - No idle cycles between lines or frames.
- Generator pixel flags:
  - tuser = 1 at (0,0).
  - tlast = 1 at h = HVALID-1.
- Counter wrap:
  - h wraps to 0 after HVALID-1, then v increments.
  - v wraps to 0 after VVALID-1.
- Pattern is latched into `cur_pat` at each (0,0) handshake, and also on restart.
- Pattern data, with tdata[23:0] = {R,G,B}:
  - coord: {2'b11, v[9:0], 2'b11, h[9:0]}.
  - bars: index b = 0..7, advancing every HVALID/8 pixels via a sub-counter (no divider). R = b[2]?FF:00, G = b[1]?FF:00, B = b[0]?FF:00.
  - solid: `solid_i`, sampled per pixel.
  - checker: (h[5]^v[5]) ? FFFFFF : 000000.

## Timing
- Reset values:
  - `active_sel` = 0, `frame_idle` = 1, generator at (0,0) with `cur_pat` = `pattern_i`.
  - `out_axis_tvalid` = 0 during reset.
  - `frame_count_o` = 0, `line_err_o` = 0, `status_o` = 2'b01.
- First cycle after `rst` falls: generator tvalid = 1, tuser = 1, tdata = pixel (0,0).
- Generator throughput is 1 pixel/cycle under constant ready. One frame = HVALID*VVALID cycles, with tlast every HVALID cycles.
- Stall behaviour: with tready = 0, tdata, tuser and tlast hold stable.
- Passthrough has zero latency.
- `sel_i` change to switch: takes effect 1 cycle after it is sampled in an idle, non-handshake cycle.
- `rst` mid-frame: tracker and generator return to reset state. The next transfer is a new frame.

## Configuration
- `TPG_STATS_EN` defined, statistics are built in:
  - `frame_count_o` increments (wrapping at 16 bits) on each tuser handshake.
  - `line_err_o` increments once per line when a tlast handshake occurs at `ocol` ≠ HVALID-1.
  - `line_err_o` also increments once per line when `ocol` reaches HVALID without tlast. This case is counted once; the next tlast of that line is not counted again.
  - Either error condition sets `status_o[1]` until reset.
- `TPG_STATS_EN` undefined: `frame_count_o`, `line_err_o` and `status_o[1]` are tied to 0, and the column error logic is removed.

## Test plan
- Generator coord, `out_axis_tready` = 1 after reset:
  - pixel 0 = 0xC00C00 with tuser; pixel 639 has tlast; pixel 640 = 0xC01C00.
  - tuser again at cycle 307200; `frame_count_o` = 2 after it.
- Bars, HVALID = 640: pixels 0..79 = 0x000000, 80 = 0x0000FF, 560..639 = 0xFFFFFF.
- Random tready (50%): output sequence identical to the constant-ready run; tdata stable whenever tvalid & !tready.
- `sel_i` = 1 asserted mid-frame:
  - generator continues to the end of frame 479 tlast.
  - then input 0 is forwarded; its tuser pixel appears unchanged.
  - `in_axis_tready[1]` stays 0 throughout.
- Input 0 sends a 639-pixel line with tlast (stats enabled): `line_err_o` = 1, `status_o` = 2'b10 mid-frame.
- `rst` asserted at pixel (100,5) for 1 cycle: next output is (0,0) with tuser, coord pattern.
